down_counter_4bit: RTL

DOWN_COUNTER_4BIT -- requirements
Module: down_counter_4bit

---
 rtl/down_counter_4bit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/down_counter_4bit.sv
// ---------------------------------------------------------------------------
// down_counter_4bit
//
// Loadable down-counter with a small IDLE/RUN/DONE controller. A load request
// with a non-zero value starts a countdown; each enabled cycle in RUN
// decrements the count. When the count reaches zero the controller spends
// exactly one cycle in DONE, pulsing done, and then returns to IDLE (or, with
// auto-reload, restarts from the last loaded value). A load request is
// honoured in every state and overrides any decrement or reload.
//
// Build option:
//   DOWN_COUNTER_AUTO_RELOAD_EN - when defined, the last non-zero value
//   accepted by a load is kept in a reload register, and DONE restarts the
//   countdown from it instead of returning to IDLE.
//
// Parameters:
//   WIDTH     count width in bits, legal range 2..16 (default 4)
//
// Ports:
//   clk       clock, all state changes on its rising edge
//   rst_n     asynchronous active-low reset (count=0, IDLE)
//   load      load request, samples load_val on this edge
//   load_val  start value for the countdown
//   enable    decrement permission while running (ignored outside RUN)
//   count     current count, registered
//   busy      high while in RUN, registered
//   done      one-cycle pulse while in DONE, registered
//   zero      combinational, high when count == 0
// ---------------------------------------------------------------------------
module down_counter_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload;
`endif

    // busy and done are registered alongside the state so each is a clean
    // flop output that always agrees with the state entered on the same edge.
    // NOTE: every register here is written with <= so all of them update from
    // the same pre-edge values; blocking assignments would let later
    // statements see half-updated state.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the reset branch sits in the sensitivity list so it acts at
        // once, without a clock; every register, including the reload value,
        // gets a defined reset so no countdown survives a reset.
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload <= '0;
`endif
        end else if (load) begin
            // A load wins in every state. Loading zero means "nothing to
            // count": park in IDLE without a done pulse.
            count <= load_val;
            done  <= 1'b0;
            if (load_val != '0) begin
                state <= RUN;
                busy  <= 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                reload <= load_val;
`endif
            end else begin
                state <= IDLE;
                busy  <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end

                RUN: begin
                    // RUN is only ever entered with a non-zero count, so
                    // stepping from 1 to 0 is the only way out and the count
                    // cannot wrap.
                    if (enable) begin
                        if (count == ONE) begin
                            count <= '0;
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            count <= count - ONE;
                        end
                    end
                end

                DONE: begin
                    done <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                    // DONE is reachable only after a non-zero load, so the
                    // reload value is non-zero here; the guard just keeps
                    // the controller out of RUN with a zero count.
                    if (reload != '0) begin
                        count <= reload;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
`else
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end

                default: begin
                    state <= IDLE;
                    count <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign zero = (count == '0);

endmodule
